id_stage: RTL and testbench

- Registered instruction-decode stage of the RV32I core, directly upstream of the ALU.
- Accepts a 32-bit instruction and PC from fetch, reads operands from an internal 32x32 register file, and decodes the opcode into the ALU's 6-bit control code.
- Forms the immediate and shift amount, then presents a single-entry registered decode packet to execute over a valid/ready handshake.
- Also hosts the writeback port of the register file.

---
 rtl/id_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: register file, ALU-control decode, registered valid/ready packet
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      alu_cntrl,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] imm_val,
    output logic [4:0]      shift_amount,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            is_branch,
    output logic            illegal,
    output logic [XLEN-1:0] out_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [5:0] ALU_ILLEGAL = 6'b111111;

    logic [XLEN-1:0] regs [1:NREGS-1];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign opcode  = in_instr[6:0];
    assign rd_idx  = in_instr[11:7];
    assign funct3  = in_instr[14:12];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];
    assign funct7  = in_instr[31:25];

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Combinational read with same-cycle writeback bypass; x0 always reads zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_idx != 5'd0)
            rs1_val = (wb_en && wb_rd == rs1_idx) ? wb_data : regs[rs1_idx];
        if (rs2_idx != 5'd0)
            rs2_val = (wb_en && wb_rd == rs2_idx) ? wb_data : regs[rs2_idx];
    end

    logic [5:0]      dec_alu;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_shamt;
    logic            dec_branch;
    logic            dec_lui;
    logic            dec_illegal;
    logic            dec_we;

    always_comb begin
        dec_alu    = ALU_ILLEGAL;
        dec_imm    = '0;
        dec_shamt  = '0;
        dec_branch = 1'b0;
        dec_lui    = 1'b0;
        case (opcode)
            OP_R: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_alu = 6'b000000;
                    {7'b0000000, 3'b001}: dec_alu = 6'b000010;
                    {7'b0000000, 3'b010}: dec_alu = 6'b000011;
                    {7'b0000000, 3'b011}: dec_alu = 6'b000100;
                    {7'b0000000, 3'b100}: dec_alu = 6'b000101;
                    {7'b0000000, 3'b101}: dec_alu = 6'b000110;
                    {7'b0000000, 3'b110}: dec_alu = 6'b001000;
                    {7'b0000000, 3'b111}: dec_alu = 6'b001001;
                    {7'b0100000, 3'b000}: dec_alu = 6'b000001;
                    {7'b0100000, 3'b101}: dec_alu = 6'b000111;
                    default: ;
                endcase
                dec_shamt = rs2_val[4:0];
            end
            OP_I: begin
                dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000: dec_alu = 6'b001010;
                    3'b010: dec_alu = 6'b001100;
                    3'b011: dec_alu = 6'b001101;
                    3'b100: dec_alu = 6'b001110;
                    3'b110: dec_alu = 6'b010000;
                    3'b111: dec_alu = 6'b010001;
                    3'b001: if (funct7 == 7'b0000000) dec_alu = 6'b000010;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec_alu = 6'b000110;
                        else if (funct7 == 7'b0100000) dec_alu = 6'b000111;
                    end
                    default: ;
                endcase
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_shamt = in_instr[24:20];
            end
            OP_LUI: begin
                // Upper immediate stays unshifted; execute applies the <<12.
                dec_alu = 6'b010010;
                dec_imm = {12'b0, in_instr[31:12]};
                dec_lui = 1'b1;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  dec_alu = 6'b011010;
                    3'b001:  dec_alu = 6'b011011;
                    3'b100:  dec_alu = 6'b011100;
                    3'b101:  dec_alu = 6'b011101;
                    default: ;
                endcase
                dec_branch = 1'b1;
                dec_imm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            end
            default: ;
        endcase
        dec_illegal = (dec_alu == ALU_ILLEGAL);
        if (dec_illegal) begin
            dec_imm    = '0;
            dec_shamt  = '0;
            dec_branch = 1'b0;
        end
        dec_we = !dec_illegal && !dec_branch && (rd_idx != 5'd0);
    end

    logic accept;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Flush outranks accept, and accept outranks the drain on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            alu_cntrl    <= '0;
            src1         <= '0;
            src2         <= '0;
            imm_val      <= '0;
            shift_amount <= '0;
            rd           <= '0;
            rd_we        <= 1'b0;
            is_branch    <= 1'b0;
            illegal      <= 1'b0;
            out_pc       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            alu_cntrl    <= dec_alu;
            src1         <= dec_lui ? '0 : rs1_val;
            src2         <= rs2_val;
            imm_val      <= dec_imm;
            shift_amount <= dec_shamt;
            rd           <= rd_idx;
            rd_we        <= dec_we;
            is_branch    <= dec_branch;
            illegal      <= dec_illegal;
            out_pc       <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage: decode table, handshake sequences, random vs model
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, src1, src2, imm_val, out_pc, wb_data;
    logic [5:0]  alu_cntrl;
    logic [4:0]  shift_amount, rd, wb_rd;
    logic        rd_we, is_branch, illegal, wb_en;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_cntrl(alu_cntrl), .src1(src1), .src2(src2),
        .imm_val(imm_val), .shift_amount(shift_amount), .rd(rd), .rd_we(rd_we),
        .is_branch(is_branch), .illegal(illegal), .out_pc(out_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  alu;
        logic [31:0] s1, s2, imm, pc;
        logic [4:0]  sh, rd;
        logic        we, br, ill;
    } pkt_t;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [4:0]  sh, rd;
        logic        ill, br, we;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mregs [32];
    logic        mv;
    pkt_t        mp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    // Decode from per-format lookup tables; 6'h3F marks an unsupported slot.
    function automatic pkt_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        logic [5:0] r_tab [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08, 6'h09};
        logic [5:0] i_tab [8] = '{6'h0A, 6'h3F, 6'h0C, 6'h0D, 6'h0E, 6'h3F, 6'h10, 6'h11};
        logic [5:0] b_tab [8] = '{6'h1A, 6'h1B, 6'h3F, 6'h3F, 6'h1C, 6'h1D, 6'h3F, 6'h3F};
        pkt_t p;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        p.s1 = mread(ins[19:15]); p.s2 = mread(ins[24:20]);
        p.alu = 6'h3F; p.imm = 0; p.sh = 0; p.br = 0;
        p.rd = ins[11:7]; p.pc = pc;
        if (op == 7'h33) begin
            if (f7 == 7'h00) p.alu = r_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) p.alu = 6'h01;
            else if (f7 == 7'h20 && f3 == 3'd5) p.alu = 6'h07;
            p.sh = p.s2[4:0];
        end else if (op == 7'h13) begin
            p.imm = 32'(signed'(ins[31:20]));
            if (f3 == 3'd1 || f3 == 3'd5) begin
                p.sh = ins[24:20];
                if (f7 == 7'h00) p.alu = (f3 == 3'd1) ? 6'h02 : 6'h06;
                else if (f7 == 7'h20 && f3 == 3'd5) p.alu = 6'h07;
            end else p.alu = i_tab[f3];
        end else if (op == 7'h37) begin
            p.alu = 6'h12; p.imm = ins >> 12; p.s1 = 0;
        end else if (op == 7'h63) begin
            p.alu = b_tab[f3]; p.br = 1;
            p.imm = 32'(signed'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end
        p.ill = (p.alu == 6'h3F);
        if (p.ill) begin p.imm = 0; p.sh = 0; p.br = 0; end
        p.we = !p.ill && !p.br && p.rd != 0;
        return p;
    endfunction

    task automatic check_pkt(input pkt_t e);
        chk("alu_cntrl", alu_cntrl, e.alu);
        chk("src1", src1, e.s1);
        chk("src2", src2, e.s2);
        chk("imm_val", imm_val, e.imm);
        chk("shift_amount", shift_amount, e.sh);
        chk("rd", rd, e.rd);
        chk("rd_we", rd_we, e.we);
        chk("is_branch", is_branch, e.br);
        chk("illegal", illegal, e.ill);
        chk("out_pc", out_pc, e.pc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        mv = 0;
    endtask

    // One clock: drive, check in_ready, advance model, clock, check outputs.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wdat);
        logic acc;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        wb_en = we; wb_rd = wrd; wb_data = wdat;
        #2;
        chk("in_ready", in_ready, !mv || ordy);
        acc = v && (!mv || ordy) && !fl;
        if (fl) mv = 0;
        else if (acc) begin mv = 1; mp = model_decode(ins, pc); end
        else if (ordy) mv = 0;
        if (we && wrd != 0) mregs[wrd] = wdat;
        @(posedge clk); #1;
        chk("out_valid", out_valid, mv);
        if (mv) check_pkt(mp);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op, f7;
        int          s, k;
        r = $urandom; s = $urandom_range(0, 9); k = $urandom_range(0, 3);
        op = (s < 3) ? 7'h33 : (s < 6) ? 7'h13 : (s == 6) ? 7'h37 : (s < 9) ? 7'h63 : r[6:0];
        f7 = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : r[31:25];
        return {f7, r[24:7], op};
    endfunction

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{32'h41F15093, 6'h07, 32'h0000041F, 5'd31, 5'd1,  1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'hABCDE237, 6'h12, 32'h000ABCDE, 5'd0,  5'd4,  1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'hFE20DCE3, 6'h1D, 32'hFFFFFFF8, 5'd0,  5'd25, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0020E063, 6'h3F, 32'h00000000, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h403100B3, 6'h01, 32'h00000000, 5'd0,  5'd1,  1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h00500013, 6'h0A, 32'h00000005, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFF00F113, 6'h11, 32'hFFFFFFF0, 5'd0,  5'd2,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h40111093, 6'h3F, 32'h00000000, 5'd0,  5'd1,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000A083, 6'h3F, 32'h00000000, 5'd0,  5'd1,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000006F, 6'h3F, 32'h00000000, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h007332B3, 6'h04, 32'h00000000, 5'd0,  5'd5,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h02000033, 6'h3F, 32'h00000000, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{32'h00001863, 6'h1B, 32'h00000010, 5'd0,  5'd16, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{32'h0041D193, 6'h06, 32'h00000004, 5'd4,  5'd3,  1'b0, 1'b0, 1'b1};

        rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
        out_ready = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset alu_cntrl", alu_cntrl, 0);
        chk("reset src1", src1, 0);
        chk("reset imm_val", imm_val, 0);
        chk("reset out_pc", out_pc, 0);
        chk("reset rd_we", rd_we, 0);
        rst_n = 1;
        #1;
        chk("reset in_ready", in_ready, 1);

        // Decode table; register file is all zero here so operands read 0.
        for (int i = 0; i < 14; i++) begin
            cyc(1, vecs[i].instr, 32'h1000 + 32'(4 * i), 1, 0, 0, 0, 0);
            chk($sformatf("vec%0d alu", i), alu_cntrl, vecs[i].alu);
            chk($sformatf("vec%0d imm", i), imm_val, vecs[i].imm);
            chk($sformatf("vec%0d sh", i), shift_amount, vecs[i].sh);
            chk($sformatf("vec%0d rd", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d ill", i), illegal, vecs[i].ill);
            chk($sformatf("vec%0d br", i), is_branch, vecs[i].br);
            chk($sformatf("vec%0d we", i), rd_we, vecs[i].we);
            chk($sformatf("vec%0d src1", i), src1, 0);
        end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);

        // Write then read, bypass, x0.
        cyc(0, 0, 0, 1, 0, 1, 5'd5, 32'hA0);
        cyc(1, 32'h005281B3, 32'h200, 1, 0, 0, 0, 0);
        chk("wr-rd src1", src1, 32'hA0);
        chk("wr-rd src2", src2, 32'hA0);
        chk("wr-rd rd", rd, 3);
        cyc(1, 32'hFFF30393, 32'h204, 1, 0, 1, 5'd6, 32'h1234);
        chk("bypass src1", src1, 32'h1234);
        chk("bypass imm", imm_val, 32'hFFFFFFFF);
        chk("bypass alu", alu_cntrl, 6'h0A);
        cyc(1, 32'h000000B3, 32'h208, 1, 0, 1, 5'd0, 32'hDEAD);
        chk("x0 bypass src1", src1, 0);
        cyc(1, 32'h000000B3, 32'h20C, 1, 0, 0, 0, 0);
        chk("x0 read src1", src1, 0);

        // Stall and hold, then drain and refill on the same edge.
        cyc(1, 32'h005281B3, 32'h300, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'hFFF30393, 32'h304, 0, 0, 1, 5'd5, 32'h55);
            chk("hold out_pc", out_pc, 32'h300);
            chk("hold src1", src1, 32'hA0);
        end
        cyc(1, 32'hFFF30393, 32'h304, 1, 0, 0, 0, 0);
        chk("no bubble out_pc", out_pc, 32'h304);

        // Flush beats hold and accept.
        cyc(1, 32'h41F15093, 32'h30C, 0, 1, 0, 0, 0);
        chk("flush out_valid", out_valid, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush not captured", out_pc, 32'h304);
        cyc(1, 32'h41F15093, 32'h310, 1, 1, 0, 0, 0);
        chk("flush idle out_valid", out_valid, 0);

        // Async reset between edges while stalled.
        cyc(1, 32'h005281B3, 32'h400, 1, 0, 0, 0, 0);
        cyc(1, 32'hFFF30393, 32'h404, 0, 0, 0, 0, 0);
        rst_n = 0;
        #2;
        chk("async out_valid", out_valid, 0);
        chk("async alu_cntrl", alu_cntrl, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 1; i < 32; i++) begin
            cyc(1, {7'h00, 5'(i), 5'(i), 3'b000, 5'd1, 7'h33}, 32'h500, 1, 0, 0, 0, 0);
            chk($sformatf("post-reset x%0d", i), src1, 0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
